// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA VRAM arbiter block.
// No logic: state encoding, default CPU address width and access-length bound.
// Imported by cga_vram_arbiter.
package cga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_ACCESS    = 2'd2,
        ST_DONE      = 2'd3
    } arb_state_e;

    localparam int CPU_ADDR_W_DEF    = 15;
    localparam int ACCESS_CYCLES_MAX = 7;
    localparam int RAM_ADDR_W        = 19;
    // Wide enough to count ACCESS_CYCLES_MAX clocks.
    localparam int ACC_CNT_W         = 3;

endpackage

// File: rtl/cga_bus_sync.sv
// Two-flop synchronizer for one asynchronous active-low ISA strobe, plus falling-edge detect.
// Latency: synced level 2 clks after the pin, fall_o pulses for one clk in the same clk the synced level drops.
// No backpressure: free-running, every clock.
module cga_bus_sync (
    input  logic clk,
    input  logic reset_l,
    input  logic strb_l_i,
    output logic strb_l_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one delayed copy for edge detection; idle level is high.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= strb_l_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign strb_l_o = sync_q;
    assign fall_o   = prev_q & ~sync_q;

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares the VRAM port between video fetch and ISA CPU cycles; video always wins, CPU uses the sequencer slot.
// Latency: start 3 clks after strobe fall; bus_rdy back high at most one slot period + ACCESS_CYCLES + 3 clks later.
// Backpressure: bus_rdy low while a CPU cycle waits; CGA_VRAM_POSTED_WRITE_EN adds a one-entry posted write buffer.
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter bit USE_BUS_WAIT  = 1'b1,
    parameter int CPU_ADDR_W    = CPU_ADDR_W_DEF,
    // Legal range 1..ACCESS_CYCLES_MAX.
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic [CPU_ADDR_W-1:0] bus_a,
    input  logic                  bus_mem_cs,
    input  logic                  bus_memr_l,
    input  logic                  bus_memw_l,
    input  logic [7:0]            bus_d,
    output logic [7:0]            bus_out,
    output logic                  bus_dir,
    output logic                  bus_rdy,
    input  logic                  isa_op_enable,
    input  logic                  vid_read,
    input  logic [18:0]           vid_a,
    output logic [18:0]           ram_a,
    input  logic [7:0]            ram_d_in,
    output logic [7:0]            ram_d_out,
    output logic                  ram_we_l
);

`ifdef CGA_VRAM_POSTED_WRITE_EN
    localparam bit POSTED_EN = 1'b1;
`else
    localparam bit POSTED_EN = 1'b0;
`endif

    logic memr_s;
    logic memr_fall;
    logic memw_s;
    logic memw_fall;

    cga_bus_sync u_sync_memr (
        .clk      (clk),
        .reset_l  (reset_l),
        .strb_l_i (bus_memr_l),
        .strb_l_o (memr_s),
        .fall_o   (memr_fall)
    );

    cga_bus_sync u_sync_memw (
        .clk      (clk),
        .reset_l  (reset_l),
        .strb_l_i (bus_memw_l),
        .strb_l_o (memw_s),
        .fall_o   (memw_fall)
    );

    arb_state_e            state_q, state_d;
    logic [ACC_CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [CPU_ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [7:0]            op_data_q, op_data_d;
    logic                  op_wr_q, op_wr_d;
    // Current op is a posted write: the CPU was already released.
    logic                  posted_q, posted_d;
    // CPU request that arrived while a posted write was still draining.
    logic                  hold_vld_q, hold_vld_d;
    logic [CPU_ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [7:0]            hold_data_q, hold_data_d;
    logic                  hold_wr_q, hold_wr_d;
    logic [7:0]            bus_out_q, bus_out_d;

    logic start;
    logic start_wr;
    logic op_strb_on;
    logic acc_last;
    logic hold_take;
    logic cpu_wait;

    // Both strobes low counts as a write, so direction follows the write strobe.
    assign start      = bus_mem_cs & (memr_fall | memw_fall);
    assign start_wr   = ~memw_s;
    assign op_strb_on = op_wr_q ? ~memw_s : ~memr_s;
    assign acc_last   = (acc_cnt_q == ACC_CNT_W'(ACCESS_CYCLES - 1));
    assign hold_take  = POSTED_EN & posted_q & start & ~hold_vld_q;

    // Next-state logic: slot wait, fixed-length access, handshake completion and posted-buffer hand-off.
    always_comb begin
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        op_addr_d   = op_addr_q;
        op_data_d   = op_data_q;
        op_wr_d     = op_wr_q;
        posted_d    = posted_q;
        hold_vld_d  = hold_vld_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_wr_d   = hold_wr_q;
        bus_out_d   = bus_out_q;

        if (hold_take) begin
            hold_vld_d  = 1'b1;
            hold_addr_d = bus_a;
            hold_data_d = bus_d;
            hold_wr_d   = start_wr;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_addr_d = bus_a;
                    op_data_d = bus_d;
                    op_wr_d   = start_wr;
                    posted_d  = POSTED_EN & start_wr;
                    state_d   = ST_WAIT_SLOT;
                end
            end
            ST_WAIT_SLOT: begin
                // A CPU that gives up before its slot leaves RAM untouched; posted writes always drain.
                if (!posted_q && !op_strb_on) begin
                    state_d = ST_IDLE;
                end else if (isa_op_enable && !vid_read) begin
                    acc_cnt_d = '0;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!acc_last) begin
                    acc_cnt_d = acc_cnt_q + ACC_CNT_W'(1);
                end else begin
                    if (!op_wr_q) begin
                        bus_out_d = ram_d_in;
                    end
                    if (!posted_q) begin
                        state_d = ST_DONE;
                    end else if (hold_vld_d) begin
                        // Queued request becomes the next op; a queued read now waits normally.
                        op_addr_d  = hold_addr_d;
                        op_data_d  = hold_data_d;
                        op_wr_d    = hold_wr_d;
                        posted_d   = hold_wr_d;
                        hold_vld_d = 1'b0;
                        state_d    = ST_WAIT_SLOT;
                    end else begin
                        posted_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (!op_strb_on) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_IDLE;
            acc_cnt_q   <= '0;
            op_addr_q   <= '0;
            op_data_q   <= 8'h00;
            op_wr_q     <= 1'b0;
            posted_q    <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= 8'h00;
            hold_wr_q   <= 1'b0;
            bus_out_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            op_addr_q   <= op_addr_d;
            op_data_q   <= op_data_d;
            op_wr_q     <= op_wr_d;
            posted_q    <= posted_d;
            hold_vld_q  <= hold_vld_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_wr_q   <= hold_wr_d;
            bus_out_q   <= bus_out_d;
        end
    end

    // Outputs decode straight from state so reset forces ram_we_l high without waiting for a clock.
    assign cpu_wait  = ((state_q == ST_WAIT_SLOT || state_q == ST_ACCESS) && !posted_q) || hold_vld_q;
    assign bus_rdy   = USE_BUS_WAIT ? ~cpu_wait : 1'b1;
    assign bus_dir   = bus_mem_cs & ~bus_memr_l;
    assign bus_out   = bus_out_q;
    assign ram_a     = (state_q == ST_ACCESS) ? RAM_ADDR_W'(op_addr_q) : vid_a;
    assign ram_d_out = op_data_q;
    // Write enable drops on the last access clk so data holds one clk past the rise.
    assign ram_we_l  = ~((state_q == ST_ACCESS) && op_wr_q && (!acc_last || ACCESS_CYCLES == 1));

endmodule

// File: tb/tb_cga_vram_arbiter.sv
module tb_cga_vram_arbiter;

    localparam int AC      = 2;
    localparam int EXP_LEN = (AC == 1) ? 1 : AC - 1;

    logic        clk = 1'b0;
    logic        reset_l;
    logic [14:0] bus_a;
    logic        bus_mem_cs;
    logic        bus_memr_l;
    logic        bus_memw_l;
    logic [7:0]  bus_d;
    logic [7:0]  bus_out;
    logic        bus_dir;
    logic        bus_rdy;
    logic        isa_op_enable;
    logic        vid_read;
    logic [18:0] vid_a;
    logic [18:0] ram_a;
    logic [7:0]  ram_d_in = 8'h00;
    logic [7:0]  ram_d_out;
    logic        ram_we_l;

    always #5 clk = ~clk;

    cga_vram_arbiter #(
        .USE_BUS_WAIT  (1'b1),
        .CPU_ADDR_W    (15),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk           (clk),
        .reset_l       (reset_l),
        .bus_a         (bus_a),
        .bus_mem_cs    (bus_mem_cs),
        .bus_memr_l    (bus_memr_l),
        .bus_memw_l    (bus_memw_l),
        .bus_d         (bus_d),
        .bus_out       (bus_out),
        .bus_dir       (bus_dir),
        .bus_rdy       (bus_rdy),
        .isa_op_enable (isa_op_enable),
        .vid_read      (vid_read),
        .vid_a         (vid_a),
        .ram_a         (ram_a),
        .ram_d_in      (ram_d_in),
        .ram_d_out     (ram_d_out),
        .ram_we_l      (ram_we_l)
    );

    typedef struct {
        bit          wr;
        logic [18:0] a;
        logic [7:0]  d;
    } sb_t;

    sb_t        exp_q[$];
    sb_t        mon_e;
    sb_t        rd_e;
    logic [7:0] mem_model [logic [18:0]];
    int         checks   = 0;
    int         failures = 0;
    int         wr_cnt   = 0;
    int         lowlen   = 0;
    logic       we_prev  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit wr, input logic [18:0] a, input logic [7:0] d);
        sb_t e;
        e.wr = wr;
        e.a  = a;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    // Pops the expected read result once the DUT has released the bus.
    task automatic pop_read(input string tag);
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            rd_e = exp_q.pop_front();
            chk({tag, "_kind"}, 32'(rd_e.wr), 32'd0);
            chk(tag, 32'(bus_out), 32'(rd_e.d));
        end
    endtask

    // Slot driver: first slot at iteration slot_c, then every period; counts clks with bus_rdy low.
    task automatic serve(input int slot_c, input bit skip_first, input int period, input int limit,
                         output int n_low, output bit done);
        n_low = 0;
        done  = 1'b0;
        for (int c = 0; c < limit && !done; c++) begin
            cyc();
            isa_op_enable = (c >= slot_c) && (((c - slot_c) % period) == 0);
            vid_read      = skip_first && (c == slot_c);
            @(negedge clk);
            if (skip_first && c == slot_c + 1) chk("skip_ram_a", 32'(ram_a), 32'(vid_a));
            if (!bus_rdy) n_low++;
            else if (n_low > 0) done = 1'b1;
        end
        cyc();
        isa_op_enable = 1'b0;
        vid_read      = 1'b0;
    endtask

    // RAM monitor: pops expected writes on each we_l fall, checks pulse width, models RAM contents.
    always @(negedge clk) begin
        if (!reset_l) begin
            lowlen = 0;
        end else begin
            if (!ram_we_l && we_prev) begin
                wr_cnt++;
                chk("wr_sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_kind", 32'(mon_e.wr), 32'd1);
                    chk("wr_addr", 32'(ram_a), 32'(mon_e.a));
                    chk("wr_data", 32'(ram_d_out), 32'(mon_e.d));
                end
            end
            if (!ram_we_l) begin
                lowlen++;
                mem_model[ram_a] = ram_d_out;
            end else if (!we_prev) begin
                chk("we_pulse_len", 32'(lowlen), 32'(EXP_LEN));
                lowlen = 0;
            end
        end
        we_prev  = ram_we_l;
        ram_d_in = mem_model.exists(ram_a) ? mem_model[ram_a] : 8'h00;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int  n_low;
        int  n;
        int  wcnt0;
        bit  done;
        bit  found;
        bit  flag;

        reset_l       = 1'b0;
        bus_a         = 15'h0;
        bus_mem_cs    = 1'b0;
        bus_memr_l    = 1'b1;
        bus_memw_l    = 1'b1;
        bus_d         = 8'h00;
        isa_op_enable = 1'b0;
        vid_read      = 1'b0;
        vid_a         = 19'h1_2345;
        mem_model[19'h07FFF] = 8'h3C;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bus_rdy", 32'(bus_rdy), 32'd1);
        chk("rst_bus_dir", 32'(bus_dir), 32'd0);
        chk("rst_bus_out", 32'(bus_out), 32'h00);
        chk("rst_ram_we_l", 32'(ram_we_l), 32'd1);
        chk("rst_ram_d_out", 32'(ram_d_out), 32'h00);
        chk("rst_ram_a", 32'(ram_a), 32'(vid_a));
        cyc();
        reset_l = 1'b1;
        repeat (2) cyc();

`ifndef CGA_VRAM_POSTED_WRITE_EN
        // Write A5 to 0123, slot 10 clks after bus_rdy drops
        vid_a      = 19'h4_5678;
        bus_a      = 15'h0123;
        bus_d      = 8'hA5;
        bus_mem_cs = 1'b1;
        bus_memw_l = 1'b0;
        push(1'b1, 19'h00123, 8'hA5);
        wcnt0 = wr_cnt;
        serve(12, 1'b0, 1000, 100, n_low, done);
        chk("wr_done", 32'(done), 32'd1);
        chk("wr_rdy_low_clks", 32'(n_low), 32'(12 + AC - 1));
        chk("wr_count", 32'(wr_cnt - wcnt0), 32'd1);
        bus_memw_l = 1'b1;
        bus_mem_cs = 1'b0;
        repeat (4) cyc();
`endif

        // Read 7FFF, RAM returns 3C
        vid_a      = 19'h2_0000;
        bus_a      = 15'h7FFF;
        bus_mem_cs = 1'b1;
        bus_memr_l = 1'b0;
        #1;
        chk("rd_bus_dir_on", 32'(bus_dir), 32'd1);
        push(1'b0, 19'h07FFF, 8'h3C);
        serve(5, 1'b0, 1000, 100, n_low, done);
        chk("rd_done", 32'(done), 32'd1);
        pop_read("rd_data");
        chk("rd_bus_dir_held", 32'(bus_dir), 32'd1);
        bus_memr_l = 1'b1;
        bus_mem_cs = 1'b0;
        #1;
        chk("rd_bus_dir_off", 32'(bus_dir), 32'd0);
        repeat (4) cyc();

`ifndef CGA_VRAM_POSTED_WRITE_EN
        // First slot taken by video, access on the second slot
        vid_a      = 19'h5_5555;
        bus_a      = 15'h0ABC;
        bus_d      = 8'h77;
        bus_mem_cs = 1'b1;
        bus_memw_l = 1'b0;
        push(1'b1, 19'h00ABC, 8'h77);
        serve(6, 1'b1, 8, 100, n_low, done);
        chk("skip_done", 32'(done), 32'd1);
        chk("skip_rdy_low_clks", 32'(n_low), 32'(14 + AC - 1));
        bus_memw_l = 1'b1;
        bus_mem_cs = 1'b0;
        repeat (4) cyc();

        // Both strobes low: executed as a write
        bus_a      = 15'h0040;
        bus_d      = 8'h5A;
        bus_mem_cs = 1'b1;
        bus_memw_l = 1'b0;
        bus_memr_l = 1'b0;
        push(1'b1, 19'h00040, 8'h5A);
        wcnt0 = wr_cnt;
        serve(4, 1'b0, 1000, 100, n_low, done);
        chk("both_done", 32'(done), 32'd1);
        chk("both_is_write", 32'(wr_cnt - wcnt0), 32'd1);
        bus_memw_l = 1'b1;
        bus_memr_l = 1'b1;
        bus_mem_cs = 1'b0;
        repeat (4) cyc();
`endif

        // Read withdrawn while waiting for a slot
        vid_a      = 19'h3_1111;
        bus_a      = 15'h0200;
        bus_mem_cs = 1'b1;
        bus_memr_l = 1'b0;
        wcnt0 = wr_cnt;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!bus_rdy) found = 1'b1;
        end
        chk("abort_rdy_low", 32'(found), 32'd1);
        cyc();
        bus_memr_l = 1'b1;
        n = 99;
        for (int i = 1; i <= 10 && n == 99; i++) begin
            cyc();
            if (bus_rdy) n = i;
        end
        chk("abort_rdy_clks_le3", 32'(n <= 3), 32'd1);
        bus_mem_cs = 1'b0;
        isa_op_enable = 1'b1;
        cyc();
        isa_op_enable = 1'b0;
        @(negedge clk);
        chk("abort_no_access_ram_a", 32'(ram_a), 32'(vid_a));
        chk("abort_no_write", 32'(wr_cnt - wcnt0), 32'd0);
        repeat (3) cyc();

        // Reset asserted in the middle of a write access
        vid_a      = 19'h6_0000;
        bus_a      = 15'h0777;
        bus_d      = 8'h99;
        bus_mem_cs = 1'b1;
        bus_memw_l = 1'b0;
        push(1'b1, 19'h00777, 8'h99);
        repeat (5) cyc();
        isa_op_enable = 1'b1;
        cyc();
        isa_op_enable = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!ram_we_l) found = 1'b1;
        end
        chk("rstmid_in_access", 32'(found), 32'd1);
        #2;
        reset_l = 1'b0;
        #1;
        chk("rstmid_we_l", 32'(ram_we_l), 32'd1);
        chk("rstmid_bus_rdy", 32'(bus_rdy), 32'd1);
        chk("rstmid_ram_a", 32'(ram_a), 32'(vid_a));
        bus_memw_l = 1'b1;
        bus_mem_cs = 1'b0;
        repeat (3) cyc();
        reset_l = 1'b1;
        repeat (3) cyc();
        wcnt0 = wr_cnt;
        chk("rstmid_post_rdy", 32'(bus_rdy), 32'd1);
        chk("rstmid_bus_out_cleared", 32'(bus_out), 32'h00);
        isa_op_enable = 1'b1;
        cyc();
        isa_op_enable = 1'b0;
        @(negedge clk);
        chk("rstmid_idle_ram_a", 32'(ram_a), 32'(vid_a));
        chk("rstmid_no_write", 32'(wr_cnt - wcnt0), 32'd0);
        repeat (3) cyc();

`ifdef CGA_VRAM_POSTED_WRITE_EN
        // Posted write: CPU never waits
        bus_a      = 15'h0010;
        bus_d      = 8'h11;
        bus_mem_cs = 1'b1;
        bus_memw_l = 1'b0;
        push(1'b1, 19'h00010, 8'h11);
        flag = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (!bus_rdy) flag = 1'b1;
        end
        chk("post_wr1_rdy_low_seen", 32'(flag), 32'd0);
        cyc();
        bus_memw_l = 1'b1;
        bus_mem_cs = 1'b0;
        repeat (4) cyc();

        // Second write waits until the first drains
        bus_a      = 15'h0020;
        bus_d      = 8'h22;
        bus_mem_cs = 1'b1;
        bus_memw_l = 1'b0;
        push(1'b1, 19'h00020, 8'h22);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!bus_rdy) found = 1'b1;
        end
        chk("post_wr2_rdy_low", 32'(found), 32'd1);
        serve(2, 1'b0, 1000, 60, n_low, done);
        chk("post_wr2_released", 32'(done), 32'd1);
        bus_memw_l = 1'b1;
        bus_mem_cs = 1'b0;
        repeat (4) cyc();

        // Read behind the still-pending write returns the written byte
        bus_a      = 15'h0020;
        bus_mem_cs = 1'b1;
        bus_memr_l = 1'b0;
        push(1'b0, 19'h00020, 8'h22);
        serve(3, 1'b0, 6, 100, n_low, done);
        chk("post_rd_done", 32'(done), 32'd1);
        pop_read("post_rd_data");
        bus_memr_l = 1'b1;
        bus_mem_cs = 1'b0;
        repeat (4) cyc();
`endif

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
